// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - E-stage multiply/divide unit owning HI/LO, fixed-latency MULT/DIV family
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are compiled in with MDU_MADD_EN.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        md_start,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_we_q, pend_we_d;

  logic        is_mul, is_div;
  logic [63:0] prod_s, prod_u, res;
  logic        res_we;
  logic [31:0] a_mag, b_mag, div_n, div_d, quo, rem;

  always_comb begin
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
    is_mul = is_mul || (op == OP_MADD) || (op == OP_MADDU) ||
             (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    is_div = (op == OP_DIV) || (op == OP_DIVU);
  end

  assign busy     = (state_q == S_RUN);
  assign md_start = start && (is_mul || is_div) && !busy;
  assign rd_data  = (op == OP_MFHI) ? hi_q : lo_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // One unsigned divider serves both DIV and DIVU; signed DIV works on magnitudes.
  // The 0x80000000 / -1 case falls out naturally: |q| = 0x80000000, sign positive.
  assign a_mag = a[31] ? (32'd0 - a) : a;
  assign b_mag = b[31] ? (32'd0 - b) : b;
  assign div_n = (op == OP_DIV) ? a_mag : a;
  assign div_d = (op == OP_DIV) ? b_mag : b;
  assign quo   = div_n / ((div_d == 32'd0) ? 32'd1 : div_d);
  assign rem   = div_n % ((div_d == 32'd0) ? 32'd1 : div_d);

  always_comb begin
    res    = 64'd0;
    res_we = 1'b1;
    case (op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV: begin
        res[63:32] = a[31] ? (32'd0 - rem) : rem;
        res[31:0]  = (a[31] ^ b[31]) ? (32'd0 - quo) : quo;
        res_we     = (b != 32'd0);
      end
      OP_DIVU: begin
        res    = {rem, quo};
        res_we = (b != 32'd0);
      end
`ifdef MDU_MADD_EN
      OP_MADD:  res = {hi_q, lo_q} + prod_s;
      OP_MADDU: res = {hi_q, lo_q} + prod_u;
      OP_MSUB:  res = {hi_q, lo_q} - prod_s;
      OP_MSUBU: res = {hi_q, lo_q} - prod_u;
`endif
      default:  res = 64'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    if (state_q == S_IDLE) begin
      if (md_start) begin
        state_d   = S_RUN;
        cnt_d     = is_div ? DIV_LOAD : MULT_LOAD;
        pend_hi_d = res[63:32];
        pend_lo_d = res[31:0];
        pend_we_d = res_we;
      end else if (start && (op == OP_MTHI)) begin
        hi_d = a;
      end else if (start && (op == OP_MTLO)) begin
        lo_d = a;
      end
    end else if (cnt_q == CNT_ONE) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      pend_we_d = 1'b0;
      if (pend_we_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end
endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - directed self-checking bench for mdu_unit (MDU_MADD_EN aware)
module tb_mdu_unit;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, md_start;
  logic [31:0] rd_data, hi, lo;
  int          checks = 0;
  int          failures = 0;
  int          cyc;
  logic        md;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .md_start(md_start), .rd_data(rd_data), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one op for a single cycle; returns md_start as seen before the edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic md_o);
    start = 1'b1; op = o; a = x; b = y;
    #1 md_o = md_start;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    // MULT -2 * 3
    issue(4'd1, 32'hFFFFFFFE, 32'd3, md);
    check("mult_md_start", {31'd0, md}, 32'd1);
    wait_idle(cyc);
    check("mult_busy_cycles", cyc, 32'd5);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFA);

    // DIV -7 / 2, then DIVU same operands, then the overflow corner
    issue(4'd3, 32'hFFFFFFF9, 32'd2, md);
    wait_idle(cyc);
    check("div_busy_cycles", cyc, 32'd10);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    op = 4'd5; #1 check("mfhi_rd", rd_data, 32'hFFFFFFFF);
    op = 4'd6; #1 check("mflo_rd", rd_data, 32'hFFFFFFFD);
    issue(4'd4, 32'hFFFFFFF9, 32'd2, md);
    wait_idle(cyc);
    check("divu_lo", lo, 32'h7FFFFFFC);
    check("divu_hi", hi, 32'd1);
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF, md);
    wait_idle(cyc);
    check("div_ovf_lo", lo, 32'h80000000);
    check("div_ovf_hi", hi, 32'd0);

    // MTHI, MULTU, then reset on busy cycle 3
    issue(4'd7, 32'h12345678, 32'd0, md);
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    issue(4'd2, 32'h00010000, 32'h00010000, md);
    op = 4'd5; #1 check("mfhi_while_busy", rd_data, 32'h12345678);
    op = 4'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_commit_hi", hi, 32'd0);
    check("abort_no_commit_lo", lo, 32'd0);

    // DIV by zero after MTLO; an MTHI attempted mid-flight must be ignored
    issue(4'd8, 32'h000000AA, 32'd0, md);
    issue(4'd3, 32'd5, 32'd0, md);
    cyc = 0;
    while (busy && cyc < 200) begin
      if (cyc == 3) begin start = 1'b1; op = 4'd7; a = 32'h55; end
      @(posedge clk); #1;
      start = 1'b0; op = 4'd0;
      cyc++;
    end
    check("div0_busy_cycles", cyc, 32'd10);
    check("div0_lo", lo, 32'h000000AA);
    check("div0_hi", hi, 32'd0);

    // MULTU max*max with back-to-back MULT in the first idle cycle
    issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, md);
    wait_idle(cyc);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'd1);
    issue(4'd1, 32'd3, 32'd4, md);
    check("b2b_md_start", {31'd0, md}, 32'd1);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_idle(cyc);
    check("b2b_busy_cycles", cyc, 32'd5);
    check("b2b_lo", lo, 32'd12);
    check("b2b_hi", hi, 32'd0);

    // MADDU 1*1 onto HI=0, LO=0xFFFFFFFF
    issue(4'd7, 32'd0, 32'd0, md);
    issue(4'd8, 32'hFFFFFFFF, 32'd0, md);
    issue(4'd10, 32'd1, 32'd1, md);
`ifdef MDU_MADD_EN
    check("maddu_md_start", {31'd0, md}, 32'd1);
    wait_idle(cyc);
    check("maddu_busy_cycles", cyc, 32'd5);
    check("maddu_hi", hi, 32'd1);
    check("maddu_lo", lo, 32'd0);
`else
    check("maddu_md_start", {31'd0, md}, 32'd0);
    check("maddu_busy", {31'd0, busy}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("maddu_hi", hi, 32'd0);
    check("maddu_lo", lo, 32'hFFFFFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
